uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 0: idle clocks inserted after each completed byte before the next tx_start.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: maximum clocks spent in HOLD before a message lock is forcibly released.
REQ-003 clk_50M  input  1  single 50 MHz clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  per-requester byte-valid; bit i = requester i.
REQ-006 req_data  input  32  packed bytes; requester i byte = bits [8i+7:8i].
REQ-007 req_last  input  4  per-requester final-byte-of-message flag, sampled with req_data.
REQ-008 gnt_ack  output  4  one-cycle pulse; bit i = requester i's byte accepted.
REQ-009 tx_start  output  1  one-cycle launch strobe to the UART transmitter.
REQ-010 tx_data  output  8  byte to transmit; stable from tx_start until tx_done.
REQ-011 tx_busy  input  1  UART transmitter busy (start bit through stop bit).
REQ-012 tx_done  input  1  one-cycle pulse at end of stop bit.
REQ-013 owner  output  2  index of the current or most recent granted requester.
REQ-014 owner_valid  output  1  high while a message is in progress (START through message release).
REQ-015 err_timeout  output  1  one-cycle pulse when a lock times out.

Function
REQ-016 States SHALL be IDLE, START, SEND, GAP, HOLD.
REQ-017 IDLE: when req!=0 and tx_busy==0, the arbiter SHALL select the first set bit at or after rr_ptr, wrapping 3->0; latch owner, byte and last flag; move to START.
REQ-018 START (exactly one cycle): tx_start=1, tx_data=latched byte, gnt_ack[owner]=1, owner_valid=1; then SEND.
REQ-019 SEND: wait for tx_done; on tx_done go to GAP if GAP_CYCLES>0, otherwise go directly to the post-gap decision.
REQ-020 Post-gap decision: if the latched last flag is 1, release the lock (owner_valid=0, rr_ptr=owner+1 mod 4) and go to IDLE; otherwise go to HOLD.
REQ-021 HOLD: only req[owner] is honoured; others wait. When req[owner]=1 and tx_busy=0, latch byte and last flag and go to START.
REQ-022 HOLD timeout: after LOCK_TIMEOUT consecutive HOLD clocks, pulse err_timeout, release the lock as in REQ-020, and go to IDLE.
REQ-023 Requesters SHALL hold req, data and last stable until their gnt_ack; the block samples these only in IDLE or HOLD on the transition to START.
REQ-024 Latency: IDLE with req rising -> tx_start 1 clock later; tx_done -> next tx_start >= GAP_CYCLES+2 clocks.
REQ-025 A tx_done outside SEND SHALL be ignored; at most one byte is outstanding at the UART.
REQ-026 Simultaneous requests with rr_ptr=2 and req=4'b1011 SHALL grant requester 3, then 0, then 1.

Reset
REQ-027 While rst=1: state=IDLE, rr_ptr=0, owner=0, tx_data=8'h00, and tx_start, gnt_ack, owner_valid and err_timeout all 0.
REQ-028 Reset mid-byte or mid-message SHALL abandon the message with no gnt_ack pulse; the first grant after reset follows REQ-017 with rr_ptr=0.

Configuration
REQ-029 Macro ARB_FIXED_PRIO_EN: when defined, IDLE selection SHALL be fixed priority (lowest index wins), rr_ptr SHALL be unused, and locking/HOLD are unchanged. When undefined, selection is round-robin per REQ-017.

Verification
REQ-030 Single byte: req=4'b0001, req_data[7:0]=8'hA5, last=1 -> tx_start with tx_data=8'hA5 and gnt_ack=4'b0001 one clock later; owner_valid drops after tx_done; rr_ptr=1.
REQ-031 Round-robin: req=4'b1111 with all last=1 held for 4 bytes -> grant order 0,1,2,3; with GAP_CYCLES=0, each tx_start is exactly 2 clocks after the previous tx_done.
REQ-032 Message lock: requester 2 sends 3 bytes (last=0,0,1) while req[0] is held -> all 3 bytes from requester 2 are sent before requester 0 is granted.
REQ-033 Timeout: LOCK_TIMEOUT=100; requester 1 sends last=0 then drops req -> err_timeout pulses 100 clocks after entering HOLD and owner_valid drops; requester 3 is granted next.
REQ-034 Reset mid-SEND: assert rst for 3 clocks during byte 8'h3C -> all outputs read 0; after release, req=4'b0110 grants requester 1 first.
REQ-035 With ARB_FIXED_PRIO_EN defined, req=4'b1010 held continuously -> requester 1 is granted every time and requester 3 is never granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four byte requesters share one UART transmitter, with per-message locking and lock timeout.
// Optional macro ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin in IDLE.
module uart_tx_arbiter #(
   parameter int GAP_CYCLES   = 0,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic        clk_50M,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_last,
   output logic [3:0]  gnt_ack,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic [1:0]  owner,
   output logic        owner_valid,
   output logic        err_timeout
);

   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
   localparam int TO_LAST  = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;
   localparam int TO_W     = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

   typedef enum logic [2:0] {IDLE, START, SEND, GAP, HOLD} state_t;

   state_t           state;
   logic             last_flag;
   logic [GAP_W-1:0] gap_cnt;
   logic [TO_W-1:0]  hold_cnt;
   logic [1:0]       pick;
   logic             hold_go;
   logic             timeout_hit;
   logic             byte_end;
   logic             release_lock;
`ifndef ARB_FIXED_PRIO_EN
   logic [1:0]       rr_ptr;
`endif

`ifdef ARB_FIXED_PRIO_EN
   function automatic logic [1:0] pick_req(input logic [3:0] r);
      pick_req = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (r[k]) pick_req = 2'(k);
      end
   endfunction
`else
   // Scanning downwards lets the nearest set bit at or after ptr win.
   function automatic logic [1:0] pick_req(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      pick_req = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (r[idx]) pick_req = idx;
      end
   endfunction
`endif

   always_comb begin
`ifdef ARB_FIXED_PRIO_EN
      pick = pick_req(req);
`else
      pick = pick_req(req, rr_ptr);
`endif
      hold_go      = (state == HOLD) && req[owner] && !tx_busy;
      timeout_hit  = (state == HOLD) && !hold_go && (hold_cnt == TO_W'(TO_LAST));
      byte_end     = ((state == SEND) && tx_done && (GAP_CYCLES == 0)) ||
                     ((state == GAP) && (gap_cnt == GAP_W'(GAP_LAST)));
      release_lock = (byte_end && last_flag) || timeout_hit;
   end

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= 2'd0;
         owner_valid <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         gnt_ack     <= 4'b0000;
         err_timeout <= 1'b0;
         last_flag   <= 1'b0;
         gap_cnt     <= '0;
         hold_cnt    <= '0;
`ifndef ARB_FIXED_PRIO_EN
         rr_ptr      <= 2'd0;
`endif
      end else begin
         tx_start    <= 1'b0;
         gnt_ack     <= 4'b0000;
         err_timeout <= 1'b0;
         unique case (state)
            IDLE: begin
               if ((req != 4'b0000) && !tx_busy) begin
                  owner       <= pick;
                  tx_data     <= req_data[{pick, 3'b000} +: 8];
                  last_flag   <= req_last[pick];
                  tx_start    <= 1'b1;
                  gnt_ack     <= 4'b0001 << pick;
                  owner_valid <= 1'b1;
                  state       <= START;
               end
            end
            START: state <= SEND;
            SEND: begin
               if (tx_done) begin
                  hold_cnt <= '0;
                  gap_cnt  <= '0;
                  if (GAP_CYCLES > 0) state <= GAP;
                  else                state <= last_flag ? IDLE : HOLD;
               end
            end
            GAP: begin
               if (byte_end) state <= last_flag ? IDLE : HOLD;
               else          gap_cnt <= gap_cnt + GAP_W'(1);
            end
            // Locked to the owner: other requesters are ignored until release.
            HOLD: begin
               if (hold_go) begin
                  tx_data   <= req_data[{owner, 3'b000} +: 8];
                  last_flag <= req_last[owner];
                  tx_start  <= 1'b1;
                  gnt_ack   <= 4'b0001 << owner;
                  state     <= START;
               end else if (timeout_hit) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + TO_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
         if (release_lock) begin
            owner_valid <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr      <= owner + 2'd1;
`endif
         end
      end
   end

endmodule
